adder: RTL and testbench

//   BUS_SIZE-bit two-operand binary adder for the MIPS datapath.

---
 rtl/adder.sv | 140 ++++++++++++++
 tb/tb_adder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/adder.sv
// ----------------------------------------------------------------------------
// adder
//   BUS_SIZE-bit two-operand binary adder for the MIPS datapath (PC+4,
//   branch-target computation). The primary result is purely combinational;
//   a registered copy of the result and its flags is also provided for
//   pipelined consumers.
//
// Ports
//   clk         in   1         clock, all registers update on rising edge
//   reset       in   1         synchronous, active-high reset
//   a, b        in   BUS_SIZE  operands (unsigned or two's complement)
//   in_valid    in   1         qualifies a/b for the registered path
//   sum         out  BUS_SIZE  combinational (a + b) mod 2^BUS_SIZE
//   carry_out   out  1         combinational unsigned carry out of the MSB
//   overflow    out  1         combinational signed overflow
//   sum_q       out  BUS_SIZE  registered sum (captured when in_valid)
//   carry_q     out  1         registered carry_out
//   overflow_q  out  1         registered overflow
//   valid_q     out  1         in_valid delayed by one cycle
// ----------------------------------------------------------------------------
module adder #(
    parameter int BUS_SIZE = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BUS_SIZE-1:0] a,
    input  logic [BUS_SIZE-1:0] b,
    input  logic                in_valid,
    output logic [BUS_SIZE-1:0] sum,
    output logic                carry_out,
    output logic                overflow,
    output logic [BUS_SIZE-1:0] sum_q,
    output logic                carry_q,
    output logic                overflow_q,
    output logic                valid_q
);

    // Number of 4-bit carry groups; the last one may be narrower.
    localparam int NG = (BUS_SIZE + 3) / 4;

    logic [BUS_SIZE-1:0] g;       // per-bit generate
    logic [BUS_SIZE-1:0] p;       // per-bit propagate
    logic [BUS_SIZE-1:0] c;       // carry into each bit
    logic [NG-1:0]       grp_g;   // group generate
    logic [NG-1:0]       grp_p;   // group propagate
    logic [NG:0]         grp_c;   // carry into each group; grp_c[NG] is carry out

    assign g = a & b;
    assign p = a ^ b;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            localparam int LO = gi * 4;
            localparam int W  = ((BUS_SIZE - LO) >= 4) ? 4 : (BUS_SIZE - LO);

            logic         gg;
            logic         gp;
            logic [W-1:0] bc;

            // Group generate/propagate depend only on this group's bits,
            // so they are available before the group carry-in arrives.
            always_comb begin
                gg = 1'b0;
                gp = 1'b1;
                for (int k = 0; k < W; k++) begin
                    gg = g[LO+k] | (p[LO+k] & gg);
                    gp = gp & p[LO+k];
                end
            end

            // Bit carries inside the group, each expanded from the group
            // carry-in through the lower bits' g/p terms.
            always_comb begin
                bc = '0;
                for (int k = 0; k < W; k++) begin
                    logic acc;
                    acc = grp_c[gi];
                    for (int j = 0; j < k; j++) begin
                        acc = g[LO+j] | (p[LO+j] & acc);
                    end
                    bc[k] = acc;
                end
            end

            assign grp_g[gi]    = gg;
            assign grp_p[gi]    = gp;
            assign c[LO +: W]   = bc;
        end
    endgenerate

    // Ripple of group carries; carry into bit 0 is zero.
    always_comb begin
        grp_c    = '0;
        grp_c[0] = 1'b0;
        for (int i = 0; i < NG; i++) begin
            grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
        end
    end

    assign sum       = p ^ c;
    assign carry_out = grp_c[NG];
    assign overflow  = (a[BUS_SIZE-1] == b[BUS_SIZE-1]) &&
                       (sum[BUS_SIZE-1] != a[BUS_SIZE-1]);

    // ------------------------------------------------------------------
    // Registered copy
    // ------------------------------------------------------------------
    logic [BUS_SIZE-1:0] sum_d;
    logic                carry_d;
    logic                overflow_d;
    logic                valid_d;

    always_comb begin
        sum_d      = sum_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        valid_d    = in_valid;
        if (in_valid) begin
            sum_d      = sum;
            carry_d    = carry_out;
            overflow_d = overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q      <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_adder.sv
module tb_adder;

    logic        clk;
    logic        clk_en;
    logic        reset;
    logic [31:0] a, b;
    logic        in_valid;
    logic [31:0] sum, sum_q;
    logic        carry_out, overflow, carry_q, overflow_q, valid_q;

    // Narrow instance with a short last carry group
    logic [5:0]  a6, b6, sum6, sum6_q;
    logic        co6, ov6, co6_q, ov6_q, v6_q;

    int errors = 0;
    int checks = 0;

    adder #(.BUS_SIZE(32)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid),
        .sum(sum), .carry_out(carry_out), .overflow(overflow),
        .sum_q(sum_q), .carry_q(carry_q), .overflow_q(overflow_q), .valid_q(valid_q)
    );

    adder #(.BUS_SIZE(6)) dut6 (
        .clk(clk), .reset(reset), .a(a6), .b(b6), .in_valid(1'b1),
        .sum(sum6), .carry_out(co6), .overflow(ov6),
        .sum_q(sum6_q), .carry_q(co6_q), .overflow_q(ov6_q), .valid_q(v6_q)
    );

    // Clock stays low until enabled so the combinational tests run unclocked.
    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        co;
        logic        ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs [9];
    logic [32:0] ref33;
    logic [31:0] seed_dummy;
    logic [6:0]  ref7;
    logic        exp_ov;

    initial begin
        clk_en   = 1'b0;
        reset    = 1'b0;
        in_valid = 1'b0;
        a = '0; b = '0; a6 = '0; b6 = '0;

        vecs[0] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[8] = '{32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0};

        // Combinational table, no clock running
        for (int i = 0; i < 9; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            #10;
            $display("vec %0d: a=%h b=%h sum=%h co=%b ov=%b", i, a, b, sum, carry_out, overflow);
            chk($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
            chk($sformatf("vec%0d_co", i), {31'b0, carry_out}, {31'b0, vecs[i].co});
            chk($sformatf("vec%0d_ov", i), {31'b0, overflow}, {31'b0, vecs[i].ov});
        end

        // Ten seeded random pairs against a 33-bit reference sum
        seed_dummy = $urandom(1658115);
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            ref33 = {1'b0, a} + {1'b0, b};
            #10;
            $display("rand %0d: a=%h b=%h sum=%h co=%b", i, a, b, sum, carry_out);
            chk($sformatf("rand%0d_sum", i), sum, ref33[31:0]);
            chk($sformatf("rand%0d_co", i), {31'b0, carry_out}, {31'b0, ref33[32]});
        end

        // Clocked path; reset wins over a simultaneous in_valid
        clk_en   = 1'b1;
        reset    = 1'b1;
        in_valid = 1'b1;
        a = 32'h0000_0005; b = 32'h0000_0006;
        #1;
        step();
        $display("reset: sum_q=%h carry_q=%b ov_q=%b valid_q=%b", sum_q, carry_q, overflow_q, valid_q);
        chk("rst_sum_q", sum_q, 32'h0);
        chk("rst_flags", {29'b0, carry_q, overflow_q, valid_q}, 32'h0);

        reset = 1'b0;
        in_valid = 1'b1;
        a = 32'h0000_0010; b = 32'h0000_0020;
        step();
        $display("cap: sum_q=%h valid_q=%b", sum_q, valid_q);
        chk("cap_sum_q", sum_q, 32'h0000_0030);
        chk("cap_flags", {29'b0, carry_q, overflow_q, valid_q}, 32'h1);

        in_valid = 1'b0;
        a = 32'hFFFF_FFFF; b = 32'h0000_0001;
        step();
        $display("hold: sum_q=%h valid_q=%b", sum_q, valid_q);
        chk("hold_sum_q", sum_q, 32'h0000_0030);
        chk("hold_flags", {29'b0, carry_q, overflow_q, valid_q}, 32'h0);

        in_valid = 1'b1;
        a = 32'h7FFF_FFFF; b = 32'h0000_0001;
        step();
        $display("ovf: sum_q=%h ov_q=%b valid_q=%b", sum_q, overflow_q, valid_q);
        chk("ovf_sum_q", sum_q, 32'h8000_0000);
        chk("ovf_flags", {29'b0, carry_q, overflow_q, valid_q}, 32'h3);

        // Mid-stream reset discards the in-flight result; comb path unaffected
        reset = 1'b1;
        in_valid = 1'b1;
        a = 32'h8000_0000; b = 32'h8000_0000;
        #1;
        $display("rst comb: sum=%h co=%b ov=%b", sum, carry_out, overflow);
        chk("rst_comb_sum", sum, 32'h0);
        chk("rst_comb_flags", {30'b0, carry_out, overflow}, 32'h3);
        step();
        $display("rst mid: sum_q=%h carry_q=%b ov_q=%b valid_q=%b", sum_q, carry_q, overflow_q, valid_q);
        chk("rst2_sum_q", sum_q, 32'h0);
        chk("rst2_flags", {29'b0, carry_q, overflow_q, valid_q}, 32'h0);

        reset = 1'b0;
        in_valid = 1'b0;
        step();
        chk("idle_flags", {29'b0, carry_q, overflow_q, valid_q}, 32'h0);

        in_valid = 1'b1;
        a = 32'hFFFF_FFFF; b = 32'h0000_0001;
        step();
        $display("first valid: sum_q=%h carry_q=%b valid_q=%b", sum_q, carry_q, valid_q);
        chk("first_sum_q", sum_q, 32'h0);
        chk("first_flags", {29'b0, carry_q, overflow_q, valid_q}, 32'h5);

        // 6-bit instance: short last group
        a6 = 6'h3F; b6 = 6'h01;
        #1;
        $display("w6: a=%h b=%h sum=%h co=%b", a6, b6, sum6, co6);
        chk("w6_sum", {26'b0, sum6}, 32'h0);
        chk("w6_co", {31'b0, co6}, 32'h1);

        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 64; j++) begin
                a6 = 6'(i);
                b6 = 6'(j);
                ref7 = {1'b0, a6} + {1'b0, b6};
                exp_ov = (a6[5] == b6[5]) && (ref7[5] != a6[5]);
                #1;
                chk($sformatf("w6_%0d_%0d", i, j), {24'b0, ov6, co6, sum6},
                    {24'b0, exp_ov, ref7});
            end
        end
        $display("w6 sweep: 4096 pairs applied");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
